regfile_mport_init: RTL

//  Parametrised register file for router buffer/VC-state storage: 1 write port, NUM_RD independent

---
 rtl/regfile_mport_init_if.sv | 25 ++
 rtl/regfile_mport_init.sv | 112 +++++++++++
 2 files changed

// File: rtl/regfile_mport_init_if.sv
// Bus bundle for regfile_mport_init: one write port, NUM_RD read ports and the READY flag.
// The master drives writes and read addresses; the slave (register file) returns read data.
interface regfile_mport_init_if #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int NUM_RD     = 2
);
  logic                         we;
  logic [ADDR_WIDTH-1:0]        addr_in;
  logic [DATA_WIDTH-1:0]        d_in;
  logic [NUM_RD-1:0]            re;
  logic [NUM_RD*ADDR_WIDTH-1:0] addr_out;
  logic [NUM_RD*DATA_WIDTH-1:0] d_out;
  logic                         ready;

  modport master (
    output we, addr_in, d_in, re, addr_out,
    input  d_out, ready
  );

  modport slave (
    input  we, addr_in, d_in, re, addr_out,
    output d_out, ready
  );
endinterface

// File: rtl/regfile_mport_init.sv
// Multi-read-port register file with a post-reset init sweep loading INIT_VAL into every entry.
// Storage has no reset; READY blocks writes and forces reads to 0 until the sweep finishes.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_INIT | sweeping INIT_VAL into arr[ptr], one entry per edge; READY=0
// ST_RUN  | array usable: writes accepted, reads return stored data; READY=1
module regfile_mport_init #(
  parameter int                    DATA_WIDTH = 1,
  parameter int                    ADDR_WIDTH = 1,
  parameter int                    DEPTH      = 1 << ADDR_WIDTH,
  parameter int                    NUM_RD     = 2,
  parameter int                    REG_OUT    = 0,
  parameter int                    BYPASS     = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input logic                 clk,
  input logic                 rst,
  regfile_mport_init_if.slave bus
);

  localparam logic [0:0]            ST_INIT   = 1'b0;
  localparam logic [0:0]            ST_RUN    = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] LAST      = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam bit                    BYPASS_EN = (BYPASS != 0);

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  run;
  logic                  wr_ok;

  logic [DATA_WIDTH-1:0] arr     [DEPTH];
  logic [ADDR_WIDTH-1:0] rd_addr [NUM_RD];
  logic                  rd_hit  [NUM_RD];
  logic [DATA_WIDTH-1:0] rd_val  [NUM_RD];

  assign run       = (state == ST_RUN);
  assign wr_ok     = ({1'b0, bus.addr_in} < DEPTH_W);
  assign bus.ready = run;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
      ptr   <= '0;
    end else if (state == ST_INIT) begin
      ptr <= ptr + 1'b1;
      if (ptr == LAST) begin
        state <= ST_RUN;
      end
    end
  end

  // ptr never exceeds DEPTH-1 while sweeping, so the init write is always in range.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        arr[ptr] <= INIT_VAL;
      end else if (bus.we && wr_ok) begin
        arr[bus.addr_in] <= bus.d_in;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_addr[i] = bus.addr_out[i*ADDR_WIDTH +: ADDR_WIDTH];
      rd_hit[i]  = BYPASS_EN && run && bus.we && wr_ok && (bus.addr_in == rd_addr[i]);
      if (!run) begin
        rd_val[i] = '0;
      end else if (rd_hit[i]) begin
        rd_val[i] = bus.d_in;
      end else if ({1'b0, rd_addr[i]} < DEPTH_W) begin
        rd_val[i] = arr[rd_addr[i]];
      end else begin
        rd_val[i] = '0;
      end
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg
      logic [DATA_WIDTH-1:0] q [NUM_RD];

      // rd_val samples arr before this edge's write, giving pre-write data without bypass.
      always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_RD; i++) begin
          if (rst) begin
            q[i] <= '0;
          end else if (bus.re[i]) begin
            q[i] <= rd_val[i];
          end
        end
      end

      always_comb begin
        bus.d_out = '0;
        for (int i = 0; i < NUM_RD; i++) begin
          bus.d_out[i*DATA_WIDTH +: DATA_WIDTH] = q[i];
        end
      end
    end else begin : g_comb
      always_comb begin
        bus.d_out = '0;
        for (int i = 0; i < NUM_RD; i++) begin
          bus.d_out[i*DATA_WIDTH +: DATA_WIDTH] = rd_val[i];
        end
      end
    end
  endgenerate

endmodule
